// File: rtl/regfile_pkg.sv
// Shared sizing for the register-file writeback path and the writeback
// source encoding used to steer the output-stage mux.
package regfile_pkg;

  localparam int REG_DATA_W   = 16;
  localparam int REG_IDX_W    = 5;
  localparam int REG_NUM_REGS = 32;

  // Which requester owns the write port this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational from the requests
// and the priority pointer; the pointer flips towards the requester that
// did not win, so two persistent requesters alternate.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  output logic gnt_0,
  output logic gnt_1
);

  logic prio_reg;
  logic prio_next;

  // Grant decode: a lone requester always wins, a tie goes by prio_reg
  always_comb begin
    gnt_0     = req_0 && (!req_1 || !prio_reg);
    gnt_1     = req_1 && (!req_0 ||  prio_reg);
    prio_next = prio_reg;
    if (gnt_0) begin
      prio_next = 1'b1;
    end else if (gnt_1) begin
      prio_next = 1'b0;
    end
  end

  // Priority pointer; holds when nobody is granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates the ALU and load-unit
// writeback ports onto a single registered write port and keeps a
// per-register pending scoreboard that stalls decode on RAW/WAW hazards,
// including the write still sitting in the output stage.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int IDX_W    = REG_IDX_W,
  parameter int NUM_REGS = REG_NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [IDX_W-1:0]    alu_index,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [IDX_W-1:0]    mem_index,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                issue_valid,
  input  logic [IDX_W-1:0]    issue_index,
  input  logic                chk_en_1,
  input  logic [IDX_W-1:0]    chk_index_1,
  input  logic                chk_en_2,
  input  logic [IDX_W-1:0]    chk_index_2,
  output logic                stall,
  output logic [IDX_W-1:0]    write_index,
  output logic [DATA_W-1:0]   write_data,
  output logic                WRITE_ENABLE,
  output logic [NUM_REGS-1:0] pending
);

  wb_src_e             grant_src;
  logic                grant;
  logic [IDX_W-1:0]    grant_index;
  logic [DATA_W-1:0]   grant_data;
  logic                issue_accept;

  logic                we_reg;
  logic [IDX_W-1:0]    widx_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] hazard_vec;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_0 (alu_valid),
    .req_1 (mem_valid),
    .gnt_0 (alu_ready),
    .gnt_1 (mem_ready)
  );

  // Steer the granted requester onto the write path
  always_comb begin
    grant_src   = SRC_NONE;
    grant_index = '0;
    grant_data  = '0;
    if (alu_ready) begin
      grant_src = SRC_ALU;
    end else if (mem_ready) begin
      grant_src = SRC_MEM;
    end
    case (grant_src)
      SRC_ALU: begin
        grant_index = alu_index;
        grant_data  = alu_data;
      end
      SRC_MEM: begin
        grant_index = mem_index;
        grant_data  = mem_data;
      end
      default: begin
        grant_index = '0;
        grant_data  = '0;
      end
    endcase
  end

  assign grant = (grant_src != SRC_NONE);

  // A register is hazardous while its write is outstanding or is being
  // written this very cycle (the register file has not absorbed it yet).
  // Set beats clear so a re-issue racing the old writeback stays pending.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign hazard_vec[gi]   = pending_reg[gi] ||
                                (we_reg && (widx_reg == IDX_W'(gi)));
      assign pending_next[gi] = (issue_accept && (issue_index == IDX_W'(gi))) ? 1'b1 :
                                (grant && (grant_index == IDX_W'(gi)))       ? 1'b0 :
                                pending_reg[gi];
    end
  endgenerate

  assign stall = (chk_en_1    && hazard_vec[chk_index_1]) ||
                 (chk_en_2    && hazard_vec[chk_index_2]) ||
                 (issue_valid && hazard_vec[issue_index]);

  assign issue_accept = issue_valid && !stall;

  // Scoreboard update; reset discards all outstanding-write tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Output stage: one-cycle registered write; index/data hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg    <= 1'b0;
      widx_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= grant;
      if (grant) begin
        widx_reg  <= grant_index;
        wdata_reg <= grant_data;
      end
    end
  end

  assign WRITE_ENABLE = we_reg;
  assign write_index  = widx_reg;
  assign write_data   = wdata_reg;
  assign pending      = pending_reg;

endmodule
